vx_commit_arbiter: RTL and testbench

Collects result beats from the per-issue-slot execution units (ALU, LSU, FPU, SFU) and merges them into a single ordered commit stream toward writeback and scoreboard release. It is the return-path counterpart of operand dispatch. One instance sits per issue slot. Arbitration is round-robin and packet-locked, so multi-beat results stay contiguous, and a 2-entry output skid buffer decouples the units from commit backpressure.

---
 rtl/vx_commit_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_vx_commit_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_commit_arbiter.sv
// vx_commit_arbiter
//   Merges result beats from the per-slot execution units (0=ALU, 1=LSU,
//   2=FPU, 3=SFU) into one ordered commit stream. Arbitration is round-robin
//   and packet-locked: once a unit starts a multi-beat packet, only that unit
//   is granted until its eop beat transfers. A 2-entry skid buffer holds
//   accepted beats, and the commit outputs come straight from its head.
//
// Configuration macro:
//   VX_COMMIT_PERF_EN - adds per-unit packet-commit and stall counters
//                       (perf_commits / perf_stalls ports).
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   unit_valid/_data/_eop/_ready   per-unit result beat input channel
//   commit_valid/_data/_eop/_unit/_ready   merged commit output channel
//   perf_commits, perf_stalls      (macro only) NUM_UNITS counters each
//
// Handshake: a beat moves on any channel in a cycle where valid && ready.
// The sender holds data/eop stable while valid && !ready. unit_ready is a
// function of unit_valid and registered state only (never commit_ready), and
// commit_* is driven from registers only.
module vx_commit_arbiter #(
  parameter int NUM_UNITS     = 4,
  parameter int DATAW         = 128,
  parameter int PERF_CTR_BITS = 44,
  localparam int UNIT_W       = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_UNITS-1:0]       unit_valid,
  input  logic [NUM_UNITS*DATAW-1:0] unit_data,
  input  logic [NUM_UNITS-1:0]       unit_eop,
  output logic [NUM_UNITS-1:0]       unit_ready,
  output logic                       commit_valid,
  output logic [DATAW-1:0]           commit_data,
  output logic                       commit_eop,
  output logic [UNIT_W-1:0]          commit_unit,
  input  logic                       commit_ready
`ifdef VX_COMMIT_PERF_EN
  ,
  output logic [NUM_UNITS*PERF_CTR_BITS-1:0] perf_commits,
  output logic [NUM_UNITS*PERF_CTR_BITS-1:0] perf_stalls
`endif
);

  logic [UNIT_W-1:0] rr_ptr_q;
  logic              lock_q;
  logic [UNIT_W-1:0] lock_unit_q;
  logic [1:0]        count_q;

  // Skid buffer: head feeds the outputs, tail is the second entry.
  logic [DATAW-1:0]  head_data_q, tail_data_q;
  logic              head_eop_q,  tail_eop_q;
  logic [UNIT_W-1:0] head_unit_q, tail_unit_q;

  logic              grant_found;
  logic [UNIT_W-1:0] grant_unit;
  logic              accept;
  logic              push;
  logic              pop;
  logic [DATAW-1:0]  push_data;
  logic              push_eop;
  logic [UNIT_W-1:0] next_ptr;

  // Grant: locked unit only while a packet is open, otherwise the first
  // valid unit scanning upward from rr_ptr with wrap-around.
  always_comb begin
    logic [UNIT_W-1:0] idx_w;
    grant_found = 1'b0;
    grant_unit  = '0;
    idx_w       = '0;
    if (lock_q) begin
      grant_found = unit_valid[lock_unit_q];
      grant_unit  = lock_unit_q;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        idx_w = UNIT_W'((int'(rr_ptr_q) + i) % NUM_UNITS);
        if (!grant_found && unit_valid[idx_w]) begin
          grant_found = 1'b1;
          grant_unit  = idx_w;
        end
      end
    end
  end

  // Accept uses the registered count, so a full buffer never takes a beat
  // even when the head pops in the same cycle; this keeps commit_ready out
  // of the unit_ready path.
  assign accept = (count_q != 2'd2);
  assign push   = accept && grant_found;
  assign pop    = (count_q != 2'd0) && commit_ready;

  always_comb begin
    unit_ready = '0;
    push_data  = '0;
    push_eop   = 1'b0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (grant_unit == UNIT_W'(u)) begin
        unit_ready[u] = push;
        push_data     = unit_data[u*DATAW +: DATAW];
        push_eop      = unit_eop[u];
      end
    end
  end

  assign next_ptr = (int'(grant_unit) == NUM_UNITS - 1) ? '0 : grant_unit + UNIT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      lock_unit_q <= '0;
      count_q     <= 2'd0;
      head_data_q <= '0;
      head_eop_q  <= 1'b0;
      head_unit_q <= '0;
      tail_data_q <= '0;
      tail_eop_q  <= 1'b0;
      tail_unit_q <= '0;
    end else begin
      if (push) begin
        if (push_eop) begin
          lock_q   <= 1'b0;
          rr_ptr_q <= next_ptr;
        end else begin
          lock_q      <= 1'b1;
          lock_unit_q <= grant_unit;
        end
      end
      case ({push, pop})
        // Push and pop together only happens at count 1: replace the head.
        2'b11: begin
          head_data_q <= push_data;
          head_eop_q  <= push_eop;
          head_unit_q <= grant_unit;
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            head_data_q <= push_data;
            head_eop_q  <= push_eop;
            head_unit_q <= grant_unit;
          end else begin
            tail_data_q <= push_data;
            tail_eop_q  <= push_eop;
            tail_unit_q <= grant_unit;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_data_q <= tail_data_q;
          head_eop_q  <= tail_eop_q;
          head_unit_q <= tail_unit_q;
          count_q     <= count_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign commit_valid = (count_q != 2'd0);
  assign commit_data  = head_data_q;
  assign commit_eop   = head_eop_q;
  assign commit_unit  = head_unit_q;

`ifdef VX_COMMIT_PERF_EN
  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_perf
    logic [PERF_CTR_BITS-1:0] commits_q;
    logic [PERF_CTR_BITS-1:0] stalls_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        commits_q <= '0;
        stalls_q  <= '0;
      end else begin
        if (unit_ready[u] && unit_eop[u]) begin
          commits_q <= commits_q + PERF_CTR_BITS'(1);
        end
        if (unit_valid[u] && !unit_ready[u]) begin
          stalls_q <= stalls_q + PERF_CTR_BITS'(1);
        end
      end
    end

    assign perf_commits[u*PERF_CTR_BITS +: PERF_CTR_BITS] = commits_q;
    assign perf_stalls[u*PERF_CTR_BITS +: PERF_CTR_BITS]  = stalls_q;
  end
`endif

endmodule

// File: tb/tb_vx_commit_arbiter.sv
// Bench for vx_commit_arbiter: per-cycle vector tables for grant/latency,
// round-robin and packet lock, hand sequences for backpressure, async reset
// and (with VX_COMMIT_PERF_EN) the perf counters. A scoreboard queue holds
// the expected commit beats {unit, eop, data} in order.
module tb_vx_commit_arbiter;
  localparam int NU = 4;
  localparam int DW = 128;
  localparam int PB = 44;

  typedef struct {
    logic [3:0]       valid;
    logic [3:0]       eop;
    logic             cr;
    logic [3:0][15:0] d;
    logic [3:0]       exp_ready;
    logic             exp_cv;
    logic [1:0]       exp_cu;
  } vec_t;

  logic              clk;
  logic              reset_n;
  logic [NU-1:0]     unit_valid;
  logic [NU*DW-1:0]  unit_data;
  logic [NU-1:0]     unit_eop;
  logic [NU-1:0]     unit_ready;
  logic              commit_valid;
  logic [DW-1:0]     commit_data;
  logic              commit_eop;
  logic [1:0]        commit_unit;
  logic              commit_ready;
`ifdef VX_COMMIT_PERF_EN
  logic [NU*PB-1:0]  perf_commits;
  logic [NU*PB-1:0]  perf_stalls;
`endif

  logic [DW-1:0]     ud [NU];
  logic [130:0]      exp_q [$];
  int                checks;
  int                failures;
  vec_t              vecs [$];

  vx_commit_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .unit_valid   (unit_valid),
    .unit_data    (unit_data),
    .unit_eop     (unit_eop),
    .unit_ready   (unit_ready),
    .commit_valid (commit_valid),
    .commit_data  (commit_data),
    .commit_eop   (commit_eop),
    .commit_unit  (commit_unit),
    .commit_ready (commit_ready)
`ifdef VX_COMMIT_PERF_EN
    ,
    .perf_commits (perf_commits),
    .perf_stalls  (perf_stalls)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int u = 0; u < NU; u++) unit_data[u*DW +: DW] = ud[u];
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [130:0] got, input logic [130:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic clear_inputs();
    unit_valid   = '0;
    unit_eop     = '0;
    commit_ready = 1'b0;
    for (int u = 0; u < NU; u++) ud[u] = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic [3:0] valid, input logic [3:0] eop, input logic cr,
                              input logic [63:0] d, input logic [3:0] er, input logic ecv,
                              input logic [1:0] ecu);
    vec_t v;
    v.valid = valid; v.eop = eop; v.cr = cr; v.d = d;
    v.exp_ready = er; v.exp_cv = ecv; v.exp_cu = ecu;
    return v;
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle (entered just after a rising edge), checks at the
  // falling edge and queues the beats the vector expects to be accepted.
  task automatic run_vec(input vec_t v, input string name);
    unit_valid   = v.valid;
    unit_eop     = v.eop;
    commit_ready = v.cr;
    for (int u = 0; u < NU; u++) ud[u] = DW'(v.d[u]);
    @(negedge clk);
    check({name, "_ready"}, unit_ready, v.exp_ready);
    check({name, "_cv"}, commit_valid, v.exp_cv);
    if (v.exp_cv) check({name, "_cu"}, commit_unit, v.exp_cu);
    for (int u = 0; u < NU; u++)
      if (v.exp_ready[u]) exp_q.push_back({2'(u), v.eop[u], DW'(v.d[u])});
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("%s%0d", name, i));
    vecs.delete();
  endtask

  task automatic end_test(input string name);
    clear_inputs();
    commit_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check({name, "_sb_empty"}, 131'(exp_q.size()), 131'd0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (reset_n && commit_valid && commit_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got=%0h exp=none", {commit_unit, commit_eop, commit_data});
      end else begin
        logic [130:0] e;
        e = exp_q.pop_front();
        if ({commit_unit, commit_eop, commit_data} !== e) begin
          failures++;
          $display("FAIL sb_beat got=%0h exp=%0h", {commit_unit, commit_eop, commit_data}, e);
        end
      end
    end
  end

  // ---------------- tests ----------------
  initial begin
    int k;
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    clear_inputs();

    // Reset state; unit_ready still follows the grant with rr_ptr=0.
    unit_valid = 4'b1100;
    @(posedge clk);
    #2;
    check("rst_cv", commit_valid, 0);
    check("rst_data", commit_data, 0);
    check("rst_eop", commit_eop, 0);
    check("rst_unit", commit_unit, 0);
    check("rst_ready", unit_ready, 4'b0100);
    do_reset();

    // Basic latency; then unit 3 wins over unit 0 because rr_ptr moved to 3.
    vecs.push_back(mk(4'b0100, 4'b0100, 1, 64'h0000_00A5_0000_0000, 4'b0100, 0, 0));
    vecs.push_back(mk(4'b1001, 4'b1001, 1, 64'h0303_0000_0000_0300, 4'b1000, 1, 2));
    vecs.push_back(mk(4'b0000, 4'b0000, 1, 64'h0,                   4'b0000, 1, 3));
    vecs.push_back(mk(4'b0000, 4'b0000, 1, 64'h0,                   4'b0000, 0, 0));
    run_table("lat");
    end_test("lat");
    do_reset();

    // Round-robin with all units valid, single-beat packets.
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(4'b1111, 4'b1111, 1, 64'h0103_0102_0101_0100,
                        4'(1 << (i % 4)), i > 0, 2'((i + 3) % 4)));
    vecs.push_back(mk(4'b0000, 4'b0000, 1, 64'h0, 4'b0000, 1, 1));
    vecs.push_back(mk(4'b0000, 4'b0000, 1, 64'h0, 4'b0000, 0, 0));
    run_table("rr");
    end_test("rr");
    do_reset();

    // Packet lock: unit 1 three beats with a 2-cycle valid gap after beat 1.
    vecs.push_back(mk(4'b0001, 4'b0001, 1, 64'h0103_0102_0000_0100, 4'b0001, 0, 0));
    vecs.push_back(mk(4'b1111, 4'b1101, 1, 64'h0103_0102_0011_0100, 4'b0010, 1, 0));
    vecs.push_back(mk(4'b1101, 4'b1101, 1, 64'h0103_0102_0000_0100, 4'b0000, 1, 1));
    vecs.push_back(mk(4'b1101, 4'b1101, 1, 64'h0103_0102_0000_0100, 4'b0000, 0, 0));
    vecs.push_back(mk(4'b1111, 4'b1101, 1, 64'h0103_0102_0012_0100, 4'b0010, 0, 0));
    vecs.push_back(mk(4'b1111, 4'b1111, 1, 64'h0103_0102_0013_0100, 4'b0010, 1, 1));
    vecs.push_back(mk(4'b1101, 4'b1101, 1, 64'h0103_0102_0000_0100, 4'b0100, 1, 1));
    vecs.push_back(mk(4'b0000, 4'b0000, 1, 64'h0,                   4'b0000, 1, 2));
    vecs.push_back(mk(4'b0000, 4'b0000, 1, 64'h0,                   4'b0000, 0, 0));
    run_table("lock");
    end_test("lock");
    do_reset();

    // Backpressure: unit 0 streams while commit_ready=0.
    k = 0;
    for (int c = 0; c < 6; c++) begin
      unit_valid = 4'b0001;
      unit_eop   = 4'b0001;
      ud[0]      = DW'(16'h0200 + k);
      @(negedge clk);
      if (unit_ready[0]) begin
        exp_q.push_back({2'd0, 1'b1, DW'(16'h0200 + k)});
        k++;
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("bp_accepted", 131'(k), 131'd2);
    check("bp_ready_low", unit_ready, 0);
    check("bp_cv_held", commit_valid, 1);
    check("bp_data_held", commit_data, 128'h200);
    @(posedge clk);
    #1;
    commit_ready = 1'b1;
    for (int c = 0; c < 40 && k < 6; c++) begin
      ud[0] = DW'(16'h0200 + k);
      @(negedge clk);
      if (unit_ready[0]) begin
        exp_q.push_back({2'd0, 1'b1, DW'(16'h0200 + k)});
        k++;
      end
      @(posedge clk);
      #1;
    end
    check("bp_total", 131'(k), 131'd6);
    end_test("bp");
    do_reset();

    // Async reset mid-packet with a full buffer.
    vecs.push_back(mk(4'b0100, 4'b0100, 1, 64'h0000_0302_0000_0000, 4'b0100, 0, 0));
    vecs.push_back(mk(4'b0010, 4'b0000, 0, 64'h0000_0000_0311_0000, 4'b0010, 1, 2));
    vecs.push_back(mk(4'b0010, 4'b0000, 0, 64'h0000_0000_0312_0000, 4'b0000, 1, 2));
    run_table("ar");
    #3;
    reset_n    = 1'b0;
    unit_valid = 4'b1001;
    unit_eop   = 4'b1001;
    #1;
    check("ar_cv_async", commit_valid, 0);
    check("ar_ready_rr0", unit_ready, 4'b0001);
    exp_q.delete();
    @(posedge clk);
    #1;
    check("ar_unit_rst", commit_unit, 0);
    reset_n = 1'b1;
    vecs.push_back(mk(4'b1000, 4'b1000, 1, 64'h0333_0000_0000_0000, 4'b1000, 0, 0));
    vecs.push_back(mk(4'b0000, 4'b0000, 1, 64'h0,                   4'b0000, 1, 3));
    vecs.push_back(mk(4'b0000, 4'b0000, 1, 64'h0,                   4'b0000, 0, 0));
    run_table("ar_post");
    end_test("ar");

`ifdef VX_COMMIT_PERF_EN
    do_reset();
    // Unit 0: two mid beats fill the buffer, 5 stall cycles, then two packets.
    vecs.push_back(mk(4'b0001, 4'b0000, 0, 64'h0040, 4'b0001, 0, 0));
    vecs.push_back(mk(4'b0001, 4'b0000, 0, 64'h0041, 4'b0001, 1, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(4'b0001, 4'b0000, 0, 64'h0042, 4'b0000, 1, 0));
    vecs.push_back(mk(4'b0000, 4'b0000, 1, 64'h0,    4'b0000, 1, 0));
    vecs.push_back(mk(4'b0001, 4'b0001, 1, 64'h0042, 4'b0001, 1, 0));
    vecs.push_back(mk(4'b0001, 4'b0001, 1, 64'h0043, 4'b0001, 1, 0));
    run_table("perf");
    @(negedge clk);
    for (int u = 0; u < NU; u++) begin
      check($sformatf("perf_commits%0d", u), perf_commits[u*PB +: PB], (u == 0) ? 2 : 0);
      check($sformatf("perf_stalls%0d", u), perf_stalls[u*PB +: PB], (u == 0) ? 5 : 0);
    end
    @(posedge clk);
    #1;
    end_test("perf");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
